// File: rtl/ofdm_rx_pkg.sv
// Shared types and width helpers for the OFDM receive symbol scheduler.
package ofdm_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CP,
    S_BODY,
    S_DONE
  } state_e;

  localparam int unsigned DEF_SYMBOLS_SIZE = 256;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Sample counter must cover both the CP length range and the FFT length.
  function automatic int unsigned cnt_width(input int unsigned cp_w, input int unsigned sym_size);
    int unsigned m;
    m = clog2(sym_size);
    return ((cp_w > m) ? cp_w : m) + 1;
  endfunction

endpackage

// File: rtl/ofdm_rx_symbol_sched_if.sv
// Sample stream in/out of the symbol scheduler, including the FFT ready handshake.
interface ofdm_rx_symbol_sched_if #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned SYM_IDX_W = 8
);
  logic                 i_valid;
  logic [DATA_SIZE-1:0] in_data_i;
  logic [DATA_SIZE-1:0] in_data_q;
  logic                 i_frame_sync;
  logic                 i_fft_ready;
  logic                 out_valid;
  logic [DATA_SIZE-1:0] out_data_i;
  logic [DATA_SIZE-1:0] out_data_q;
  logic                 o_sop;
  logic                 o_eop;
  logic [SYM_IDX_W-1:0] o_sym_idx;

  modport slave (
    input  i_valid, in_data_i, in_data_q, i_frame_sync, i_fft_ready,
    output out_valid, out_data_i, out_data_q, o_sop, o_eop, o_sym_idx
  );

  modport master (
    output i_valid, in_data_i, in_data_q, i_frame_sync, i_fft_ready,
    input  out_valid, out_data_i, out_data_q, o_sop, o_eop, o_sym_idx
  );
endinterface

// File: rtl/ofdm_sym_window_cnt.sv
// Loadable valid-sample counter for CP/BODY windows; wraps to 0 on terminal count.
module ofdm_sym_window_cnt #(
  parameter int unsigned W = 9
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // load_i makes the current sample count as index 0 of a freshly started window.
  always_comb begin
    cnt_o = load_i ? '0 : cnt_q;
    tc_o  = (cnt_o == last_i);
    cnt_d = cnt_o;
    if (inc_i) cnt_d = tc_o ? '0 : cnt_o + W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ofdm_rx_symbol_sched.sv
// Receive symbol scheduler: strips CP, forwards FFT-body samples with sop/eop/index,
// drops symbols the FFT cannot take, and flags frame completion and sync errors.
module ofdm_rx_symbol_sched
  import ofdm_rx_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 16,
  parameter int unsigned SYMBOLS_SIZE = DEF_SYMBOLS_SIZE,
  parameter int unsigned CP_W         = 8,
  parameter int unsigned SYM_IDX_W    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [SYM_IDX_W-1:0] i_num_symbols,
  input  logic [CP_W-1:0]      i_cp_first,
  input  logic [CP_W-1:0]      i_cp_normal,
  ofdm_rx_symbol_sched_if.slave strm,
  output logic                 o_frame_done,
  output logic                 o_drop,
  output logic                 o_sync_err,
  output logic                 o_busy
);
  localparam int unsigned CNT_W = cnt_width(CP_W, SYMBOLS_SIZE);

  state_e               state_q, state_d, st_w;
  logic [SYM_IDX_W-1:0] sym_q, sym_d, sym_w;
  logic [SYM_IDX_W-1:0] num_q, num_d, num_w;
  logic [CP_W-1:0]      cpn_q, cpn_d, cpn_w;
  logic [CP_W-1:0]      cplen_q, cplen_d, cplen_w;
  logic                 keep_q, keep_d, keep_w;
  logic                 mid, restart, load, inc, win_cp, win_body, tc;
  logic [CNT_W-1:0]     last, cnt;

  logic                 out_valid_q, out_valid_d;
  logic [DATA_SIZE-1:0] data_i_q, data_i_d, data_q_q, data_q_d;
  logic                 sop_q, sop_d, eop_q, eop_d;
  logic [SYM_IDX_W-1:0] idx_q, idx_d;
  logic                 done_q, done_d, drop_q, drop_d, err_q, err_d;

  // Sync decoding first: a restart makes this cycle's sample index 0 of the new frame.
  always_comb begin
    st_w    = (state_q == S_DONE) ? S_IDLE : state_q;
    mid     = (state_q == S_CP) || (state_q == S_BODY);
    load    = 1'b0;
    restart = 1'b0;
    err_d   = 1'b0;
    cplen_w = cplen_q;
    num_w   = num_q;
    cpn_w   = cpn_q;
    if (strm.i_frame_sync && (mid || i_enable)) begin
      err_d = mid || (i_num_symbols == '0);
      load  = 1'b1;
      if (i_num_symbols == '0) begin
        st_w = S_IDLE;
      end else begin
        restart = 1'b1;
        cplen_w = i_cp_first;
        num_w   = i_num_symbols;
        cpn_w   = i_cp_normal;
        st_w    = (i_cp_first == '0) ? S_BODY : S_CP;
      end
    end
    sym_w    = restart ? '0 : sym_q;
    win_cp   = (st_w == S_CP);
    win_body = (st_w == S_BODY);
    inc      = strm.i_valid && (win_cp || win_body);
    last     = win_cp ? CNT_W'(cplen_w) - CNT_W'(1) : CNT_W'(SYMBOLS_SIZE - 1);
  end

  ofdm_sym_window_cnt #(.W(CNT_W)) u_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .load_i  (load),
    .inc_i   (inc),
    .last_i  (last),
    .cnt_o   (cnt),
    .tc_o    (tc)
  );

  always_comb begin
    state_d     = st_w;
    sym_d       = sym_w;
    num_d       = num_w;
    cpn_d       = cpn_w;
    cplen_d     = cplen_w;
    keep_w      = keep_q;
    keep_d      = keep_q;
    out_valid_d = 1'b0;
    data_i_d    = '0;
    data_q_d    = '0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    idx_d       = '0;
    drop_d      = 1'b0;
    done_d      = (state_q == S_DONE);
    if (strm.i_valid && win_body) begin
      if (cnt == '0) begin
        keep_w = strm.i_fft_ready;
        drop_d = !strm.i_fft_ready;
      end
      keep_d = keep_w;
      if (keep_w) begin
        out_valid_d = 1'b1;
        data_i_d    = strm.in_data_i;
        data_q_d    = strm.in_data_q;
        sop_d       = (cnt == '0);
        eop_d       = tc;
        idx_d       = sym_w;
      end
      if (tc) begin
        if (sym_w == num_w - SYM_IDX_W'(1)) begin
          state_d = S_DONE;
        end else begin
          sym_d   = sym_w + SYM_IDX_W'(1);
          cplen_d = cpn_w;
          state_d = (cpn_w == '0) ? S_BODY : S_CP;
        end
      end
    end else if (strm.i_valid && win_cp && tc) begin
      state_d = S_BODY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      sym_q       <= '0;
      num_q       <= '0;
      cpn_q       <= '0;
      cplen_q     <= '0;
      keep_q      <= 1'b0;
      out_valid_q <= 1'b0;
      data_i_q    <= '0;
      data_q_q    <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      num_q       <= num_d;
      cpn_q       <= cpn_d;
      cplen_q     <= cplen_d;
      keep_q      <= keep_d;
      out_valid_q <= out_valid_d;
      data_i_q    <= data_i_d;
      data_q_q    <= data_q_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  assign strm.out_valid  = out_valid_q;
  assign strm.out_data_i = data_i_q;
  assign strm.out_data_q = data_q_q;
  assign strm.o_sop      = sop_q;
  assign strm.o_eop      = eop_q;
  assign strm.o_sym_idx  = idx_q;
  assign o_frame_done    = done_q;
  assign o_drop          = drop_q;
  assign o_sync_err      = err_q;
  assign o_busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_ofdm_rx_symbol_sched.sv
// Directed bench for ofdm_rx_symbol_sched with SYMBOLS_SIZE=16.
module tb_ofdm_rx_symbol_sched;
  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_enable = 1'b1;
  logic [7:0] i_num_symbols = 8'd3;
  logic [7:0] i_cp_first = 8'd4;
  logic [7:0] i_cp_normal = 8'd2;
  logic       o_frame_done, o_drop, o_sync_err, o_busy;

  ofdm_rx_symbol_sched_if #(.DATA_SIZE(16), .SYM_IDX_W(8)) bus ();

  ofdm_rx_symbol_sched #(
    .DATA_SIZE(16), .SYMBOLS_SIZE(16), .CP_W(8), .SYM_IDX_W(8)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_num_symbols(i_num_symbols), .i_cp_first(i_cp_first), .i_cp_normal(i_cp_normal),
    .strm(bus), .o_frame_done(o_frame_done), .o_drop(o_drop),
    .o_sync_err(o_sync_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int sidx = 0;
  int drop_at = -1;

  int vdat[$], sop_cyc[$], sop_idx[$], sop_dat[$], eop_cyc[$], eop_dat[$];
  int done_cyc[$], drop_cyc[$], err_cyc[$];
  int nvalid = 0, zero_viol = 0;
  bit busy_seen = 1'b0;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      nvalid++;
      vdat.push_back(int'(bus.out_data_i));
      if (bus.out_data_q !== ~bus.out_data_i) zero_viol++;
    end else if (bus.out_data_i !== '0 || bus.out_data_q !== '0) begin
      zero_viol++;
    end
    if (bus.o_sop) begin
      sop_cyc.push_back(cyc); sop_idx.push_back(int'(bus.o_sym_idx)); sop_dat.push_back(int'(bus.out_data_i));
    end
    if (bus.o_eop) begin
      eop_cyc.push_back(cyc); eop_dat.push_back(int'(bus.out_data_i));
    end
    if (o_frame_done) done_cyc.push_back(cyc);
    if (o_drop) drop_cyc.push_back(cyc);
    if (o_sync_err) err_cyc.push_back(cyc);
    if (o_busy) busy_seen = 1'b1;
  end

  task automatic clr();
    vdat.delete(); sop_cyc.delete(); sop_idx.delete(); sop_dat.delete();
    eop_cyc.delete(); eop_dat.delete(); done_cyc.delete(); drop_cyc.delete(); err_cyc.delete();
    nvalid = 0; zero_viol = 0; busy_seen = 1'b0;
  endtask

  // Presents one cycle of input; the DUT samples it at the next rising edge.
  task automatic step(input bit v, input bit sync);
    bus.i_valid      = v;
    bus.i_frame_sync = sync;
    bus.in_data_i    = v ? 16'(sidx) : 16'h0;
    bus.in_data_q    = v ? ~16'(sidx) : 16'h0;
    bus.i_fft_ready  = !(v && sidx == drop_at);
    @(posedge clk); #1;
    if (v) sidx++;
    bus.i_valid = 1'b0; bus.i_frame_sync = 1'b0;
    bus.in_data_i = '0; bus.in_data_q = '0; bus.i_fft_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic run_frame(input int nsamp, input bit gapped, output int t0);
    sidx = 0;
    t0 = cyc;
    for (int k = 0; k < nsamp; k++) begin
      step(1'b1, k == 0);
      if (gapped) step(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.out_data_i !== 16'h0) begin errors++; $display("FAIL rst_data got %0h exp 0", bus.out_data_i); end
    checks++; if ({bus.o_sop, bus.o_eop, o_frame_done, o_drop, o_sync_err} !== 5'b0) begin errors++; $display("FAIL rst_flags got %05b exp 00000", {bus.o_sop, bus.o_eop, o_frame_done, o_drop, o_sync_err}); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", o_busy); end
    i_reset = 1'b0;
    idle(2);
  endtask

  task automatic test_nominal();
    int t0, mism;
    clr(); i_cp_first = 8'd4; i_cp_normal = 8'd2; i_num_symbols = 8'd3;
    run_frame(56, 1'b0, t0);
    idle(4);
    checks++; if (nvalid !== 48) begin errors++; $display("FAIL nom_nvalid got %0d exp 48", nvalid); end
    checks++; if (sop_cyc.size() !== 3 || sop_cyc[0] !== t0 + 5 || sop_cyc[1] !== t0 + 23 || sop_cyc[2] !== t0 + 41) begin errors++; $display("FAIL nom_sop got n=%0d first=%0d exp n=3 first=%0d", sop_cyc.size(), sop_cyc[0], t0 + 5); end
    checks++; if (sop_idx[0] !== 0 || sop_idx[1] !== 1 || sop_idx[2] !== 2) begin errors++; $display("FAIL nom_idx got %0d %0d %0d exp 0 1 2", sop_idx[0], sop_idx[1], sop_idx[2]); end
    checks++; if (eop_cyc.size() !== 3 || eop_cyc[0] !== t0 + 20 || eop_cyc[1] !== t0 + 38 || eop_cyc[2] !== t0 + 56) begin errors++; $display("FAIL nom_eop got n=%0d first=%0d exp n=3 first=%0d", eop_cyc.size(), eop_cyc[0], t0 + 20); end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== t0 + 57) begin errors++; $display("FAIL nom_done got n=%0d at %0d exp n=1 at %0d", done_cyc.size(), done_cyc[0], t0 + 57); end
    mism = 0;
    for (int n = 0; n < vdat.size(); n++) if (vdat[n] !== 4 + (n / 16) * 18 + (n % 16)) mism++;
    checks++; if (mism !== 0) begin errors++; $display("FAIL nom_data got %0d bad samples exp 0", mism); end
    checks++; if (zero_viol !== 0) begin errors++; $display("FAIL nom_idle_zero got %0d violations exp 0", zero_viol); end
    checks++; if (drop_cyc.size() + err_cyc.size() !== 0) begin errors++; $display("FAIL nom_noflags got %0d exp 0", drop_cyc.size() + err_cyc.size()); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL nom_busy_end got %0b exp 0", o_busy); end
  endtask

  task automatic test_gapped();
    int t0;
    clr();
    run_frame(56, 1'b1, t0);
    idle(4);
    checks++; if (nvalid !== 48) begin errors++; $display("FAIL gap_nvalid got %0d exp 48", nvalid); end
    checks++; if (sop_dat.size() !== 3 || sop_dat[0] !== 4 || sop_dat[1] !== 22 || sop_dat[2] !== 40) begin errors++; $display("FAIL gap_sop_dat got %0d %0d %0d exp 4 22 40", sop_dat[0], sop_dat[1], sop_dat[2]); end
    checks++; if (eop_dat.size() !== 3 || eop_dat[0] !== 19 || eop_dat[1] !== 37 || eop_dat[2] !== 55) begin errors++; $display("FAIL gap_eop_dat got %0d %0d %0d exp 19 37 55", eop_dat[0], eop_dat[1], eop_dat[2]); end
    checks++; if (sop_cyc[1] !== t0 + 45) begin errors++; $display("FAIL gap_sop1_cyc got %0d exp %0d", sop_cyc[1], t0 + 45); end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== t0 + 112) begin errors++; $display("FAIL gap_done got %0d exp %0d", done_cyc[0], t0 + 112); end
  endtask

  task automatic test_drop();
    int t0;
    clr(); drop_at = 22;
    run_frame(56, 1'b0, t0);
    idle(4);
    drop_at = -1;
    checks++; if (drop_cyc.size() !== 1 || drop_cyc[0] !== t0 + 23) begin errors++; $display("FAIL drop_pulse got n=%0d at %0d exp n=1 at %0d", drop_cyc.size(), drop_cyc[0], t0 + 23); end
    checks++; if (nvalid !== 32) begin errors++; $display("FAIL drop_nvalid got %0d exp 32", nvalid); end
    checks++; if (sop_idx.size() !== 2 || sop_idx[0] !== 0 || sop_idx[1] !== 2 || sop_dat[1] !== 40) begin errors++; $display("FAIL drop_idx got n=%0d %0d %0d exp n=2 0 2", sop_idx.size(), sop_idx[0], sop_idx[1]); end
    checks++; if (eop_cyc.size() !== 2) begin errors++; $display("FAIL drop_eop got %0d exp 2", eop_cyc.size()); end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== t0 + 57) begin errors++; $display("FAIL drop_done got %0d exp %0d", done_cyc[0], t0 + 57); end
  endtask

  task automatic test_mid_sync();
    int ts;
    clr(); sidx = 0;
    for (int k = 0; k < 29; k++) step(1'b1, k == 0);
    ts = cyc; sidx = 0;
    for (int k = 0; k < 56; k++) step(1'b1, k == 0);
    idle(4);
    checks++; if (err_cyc.size() !== 1 || err_cyc[0] !== ts + 1) begin errors++; $display("FAIL msync_err got n=%0d at %0d exp n=1 at %0d", err_cyc.size(), err_cyc[0], ts + 1); end
    checks++; if (sop_cyc.size() !== 5 || sop_cyc[2] !== ts + 5 || sop_idx[2] !== 0) begin errors++; $display("FAIL msync_sop got n=%0d at %0d idx %0d exp n=5 at %0d idx 0", sop_cyc.size(), sop_cyc[2], sop_idx[2], ts + 5); end
    checks++; if (eop_cyc.size() !== 4) begin errors++; $display("FAIL msync_eop got %0d exp 4", eop_cyc.size()); end
    checks++; if (nvalid !== 71) begin errors++; $display("FAIL msync_nvalid got %0d exp 71", nvalid); end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== ts + 57) begin errors++; $display("FAIL msync_done got %0d exp %0d", done_cyc[0], ts + 57); end
  endtask

  task automatic test_zero_cp();
    int t0;
    clr(); i_cp_first = 8'd0; i_cp_normal = 8'd0;
    run_frame(48, 1'b0, t0);
    idle(4);
    checks++; if (sop_cyc.size() !== 3 || sop_cyc[0] !== t0 + 1 || sop_cyc[1] !== t0 + 17 || sop_cyc[2] !== t0 + 33) begin errors++; $display("FAIL zcp_sop got n=%0d first=%0d exp n=3 first=%0d", sop_cyc.size(), sop_cyc[0], t0 + 1); end
    checks++; if (eop_cyc.size() !== 3 || eop_cyc[2] !== t0 + 48 || eop_dat[0] !== 15) begin errors++; $display("FAIL zcp_eop got n=%0d last=%0d exp n=3 last=%0d", eop_cyc.size(), eop_cyc[2], t0 + 48); end
    checks++; if (nvalid !== 48) begin errors++; $display("FAIL zcp_nvalid got %0d exp 48", nvalid); end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== t0 + 49) begin errors++; $display("FAIL zcp_done got %0d exp %0d", done_cyc[0], t0 + 49); end
    i_cp_first = 8'd4; i_cp_normal = 8'd2;
  endtask

  task automatic test_bad_sync();
    int t0;
    clr(); i_num_symbols = 8'd0; sidx = 0; t0 = cyc;
    step(1'b1, 1'b1);
    idle(3);
    checks++; if (err_cyc.size() !== 1 || err_cyc[0] !== t0 + 1) begin errors++; $display("FAIL num0_err got n=%0d at %0d exp n=1 at %0d", err_cyc.size(), err_cyc[0], t0 + 1); end
    checks++; if (busy_seen !== 1'b0 || nvalid !== 0) begin errors++; $display("FAIL num0_busy got %0b/%0d exp 0/0", busy_seen, nvalid); end
    clr(); i_num_symbols = 8'd3; i_enable = 1'b0;
    step(1'b1, 1'b1);
    idle(3);
    checks++; if (busy_seen !== 1'b0 || err_cyc.size() !== 0) begin errors++; $display("FAIL dis_sync got busy %0b err %0d exp 0 0", busy_seen, err_cyc.size()); end
    i_enable = 1'b1;
  endtask

  task automatic test_reset_mid_body();
    sidx = 0;
    for (int k = 0; k < 10; k++) step(1'b1, k == 0);
    checks++; if (bus.out_valid !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL rmb_pre got %0b%0b exp 11", bus.out_valid, o_busy); end
    i_reset = 1'b1;
    step(1'b1, 1'b0);
    checks++; if ({bus.out_valid, bus.o_sop, bus.o_eop, o_busy, o_drop, o_sync_err, o_frame_done} !== 7'b0 || bus.out_data_i !== 16'h0 || bus.o_sym_idx !== 8'h0) begin errors++; $display("FAIL rmb_outputs got %07b data %0h exp 0000000 data 0", {bus.out_valid, bus.o_sop, bus.o_eop, o_busy, o_drop, o_sync_err, o_frame_done}, bus.out_data_i); end
    i_reset = 1'b0;
    clr();
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0);
    checks++; if (nvalid !== 0 || busy_seen !== 1'b0) begin errors++; $display("FAIL rmb_idle got nvalid %0d busy %0b exp 0 0", nvalid, busy_seen); end
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_frame_sync = 1'b0; bus.i_fft_ready = 1'b1;
    bus.in_data_i = '0; bus.in_data_q = '0;
    test_reset();
    test_nominal();
    test_gapped();
    test_drop();
    test_mid_sync();
    test_zero_cp();
    test_bad_sync();
    test_reset_mid_body();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
